// File: rtl/clock_pkg.sv
// Shared layout, limits and state encoding for the time-of-day set controller.
package clock_pkg;

    localparam int TIME_W = 20;

    // Field widths and LSB offsets inside the packed time word
    localparam int HH_W = 2;
    localparam int HL_W = 4;
    localparam int MH_W = 3;
    localparam int ML_W = 4;
    localparam int SH_W = 3;
    localparam int SL_W = 4;
    localparam int SL_LSB = 0;
    localparam int SH_LSB = 4;
    localparam int ML_LSB = 7;
    localparam int MH_LSB = 11;
    localparam int HL_LSB = 14;
    localparam int HH_LSB = 18;

    localparam int HOUR_MAX   = 23;
    localparam int MINSEC_MAX = 59;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_EDIT_H,
        ST_EDIT_M,
        ST_EDIT_S,
        ST_COMMIT
    } state_t;

    localparam logic [1:0] ES_RUN  = 2'd0;
    localparam logic [1:0] ES_HOUR = 2'd1;
    localparam logic [1:0] ES_MIN  = 2'd2;
    localparam logic [1:0] ES_SEC  = 2'd3;

    // True when a tens/units BCD pair is a legal digit pair not above max
    function automatic logic bcd_ok(input logic [3:0] tens, input logic [3:0] units,
                                    input int max);
        return (units <= 4'd9) && ((int'(tens) * 10 + int'(units)) <= max);
    endfunction

endpackage

// File: rtl/bcd_field_step.sv
// One BCD field (tens/units) stepped up or down by one with wrap at 00 / max.
module bcd_field_step #(
    parameter int TW = 3
) (
    input  logic [TW-1:0] i_tens,
    input  logic [3:0]    i_units,
    input  logic [TW-1:0] i_max_tens,
    input  logic [3:0]    i_max_units,
    input  logic          i_inc,
    input  logic          i_dec,
    output logic [TW-1:0] o_tens,
    output logic [3:0]    o_units
);

    always_comb begin
        o_tens  = i_tens;
        o_units = i_units;
        if (i_inc && !i_dec) begin
            if (i_tens == i_max_tens && i_units == i_max_units) begin
                o_tens  = '0;
                o_units = '0;
            end else if (i_units == 4'd9) begin
                o_tens  = i_tens + TW'(1);
                o_units = '0;
            end else begin
                o_units = i_units + 4'd1;
            end
        end else if (i_dec && !i_inc) begin
            if (i_tens == '0 && i_units == 4'd0) begin
                o_tens  = i_max_tens;
                o_units = i_max_units;
            end else if (i_units == 4'd0) begin
                o_tens  = i_tens - TW'(1);
                o_units = 4'd9;
            end else begin
                o_units = i_units - 4'd1;
            end
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Freezes the time counter, edits a sanitised shadow copy field by field and
// commits it through the counter load port; abandons the edit after inactivity.
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 20,
    parameter int TO_W          = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              btn_mode,
    input  logic              btn_inc,
    input  logic              btn_dec,
    input  logic              tick_blink,
    input  logic [TIME_W-1:0] cur_time,
    output logic              run_en,
    output logic              load_en,
    output logic [TIME_W-1:0] load_time,
    output logic [5:0]        blink_mask,
    output logic [1:0]        edit_state
);

    state_t            r_state, w_state_nx;
    logic [TIME_W-1:0] r_shadow, w_shadow_nx;
    logic [TO_W-1:0]   r_to, w_to_nx;
    logic              r_phase, w_phase_nx;
    logic              r_run_en, r_load_en;
    logic [5:0]        r_mask, w_mask_nx;
    logic [1:0]        r_es, w_es_nx;

    logic              w_h_ok, w_m_ok, w_s_ok;
    logic [TIME_W-1:0] w_cap, w_stepped;
    logic [HH_W-1:0]   w_hh_nx;
    logic [MH_W-1:0]   w_mh_nx;
    logic [SH_W-1:0]   w_sh_nx;
    logic [3:0]        w_hl_nx, w_ml_nx, w_sl_nx;
    logic              w_sel_h, w_sel_m, w_sel_s;

    // Any garbage field from the counter is zeroed so edits start from a legal value
    assign w_h_ok = bcd_ok({2'b00, cur_time[HH_LSB +: HH_W]}, cur_time[HL_LSB +: HL_W], HOUR_MAX);
    assign w_m_ok = bcd_ok({1'b0, cur_time[MH_LSB +: MH_W]}, cur_time[ML_LSB +: ML_W], MINSEC_MAX);
    assign w_s_ok = bcd_ok({1'b0, cur_time[SH_LSB +: SH_W]}, cur_time[SL_LSB +: SL_W], MINSEC_MAX);
    assign w_cap  = {w_h_ok ? cur_time[19:14] : 6'd0,
                     w_m_ok ? cur_time[13:7]  : 7'd0,
                     w_s_ok ? cur_time[6:0]   : 7'd0};

    assign w_sel_h = (r_state == ST_EDIT_H);
    assign w_sel_m = (r_state == ST_EDIT_M);
    assign w_sel_s = (r_state == ST_EDIT_S);

    bcd_field_step #(.TW(HH_W)) u_step_h (
        .i_tens      (r_shadow[HH_LSB +: HH_W]),
        .i_units     (r_shadow[HL_LSB +: HL_W]),
        .i_max_tens  (HH_W'(HOUR_MAX / 10)),
        .i_max_units (4'(HOUR_MAX % 10)),
        .i_inc       (btn_inc && w_sel_h),
        .i_dec       (btn_dec && w_sel_h),
        .o_tens      (w_hh_nx),
        .o_units     (w_hl_nx)
    );

    bcd_field_step #(.TW(MH_W)) u_step_m (
        .i_tens      (r_shadow[MH_LSB +: MH_W]),
        .i_units     (r_shadow[ML_LSB +: ML_W]),
        .i_max_tens  (MH_W'(MINSEC_MAX / 10)),
        .i_max_units (4'(MINSEC_MAX % 10)),
        .i_inc       (btn_inc && w_sel_m),
        .i_dec       (btn_dec && w_sel_m),
        .o_tens      (w_mh_nx),
        .o_units     (w_ml_nx)
    );

    bcd_field_step #(.TW(SH_W)) u_step_s (
        .i_tens      (r_shadow[SH_LSB +: SH_W]),
        .i_units     (r_shadow[SL_LSB +: SL_W]),
        .i_max_tens  (SH_W'(MINSEC_MAX / 10)),
        .i_max_units (4'(MINSEC_MAX % 10)),
        .i_inc       (btn_inc && w_sel_s),
        .i_dec       (btn_dec && w_sel_s),
        .o_tens      (w_sh_nx),
        .o_units     (w_sl_nx)
    );

    assign w_stepped = {w_hh_nx, w_hl_nx, w_mh_nx, w_ml_nx, w_sh_nx, w_sl_nx};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= ST_RUN;
            r_shadow <= '0;
            r_to     <= '0;
            r_phase  <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_shadow <= w_shadow_nx;
            r_to     <= w_to_nx;
            r_phase  <= w_phase_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_shadow_nx = r_shadow;
        w_to_nx     = r_to;
        w_phase_nx  = r_phase;
        case (r_state)
            ST_RUN: begin
                w_to_nx    = '0;
                w_phase_nx = 1'b0;
                if (btn_mode) begin
                    w_state_nx  = ST_EDIT_H;
                    w_shadow_nx = w_cap;
                end
            end
            ST_EDIT_H, ST_EDIT_M, ST_EDIT_S: begin
                if (btn_mode) begin
                    w_state_nx = (r_state == ST_EDIT_H) ? ST_EDIT_M :
                                 (r_state == ST_EDIT_M) ? ST_EDIT_S : ST_COMMIT;
                    w_to_nx    = '0;
                    w_phase_nx = 1'b0;
                end else if (btn_inc || btn_dec) begin
                    w_shadow_nx = w_stepped;
                    w_to_nx     = '0;
                    w_phase_nx  = 1'b0;
                end else if (tick_blink) begin
                    if (r_to == TO_W'(TIMEOUT_TICKS - 1)) begin
                        w_state_nx = ST_RUN;
                        w_to_nx    = '0;
                        w_phase_nx = 1'b0;
                    end else begin
                        w_to_nx    = r_to + TO_W'(1);
                        w_phase_nx = ~r_phase;
                    end
                end
            end
            ST_COMMIT: w_state_nx = ST_RUN;
            default:   w_state_nx = ST_RUN;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register
    always_comb begin
        w_mask_nx = 6'b000000;
        w_es_nx   = ES_RUN;
        case (w_state_nx)
            ST_EDIT_H: begin w_es_nx = ES_HOUR; w_mask_nx = {{2{w_phase_nx}}, 4'b0000}; end
            ST_EDIT_M: begin w_es_nx = ES_MIN;  w_mask_nx = {2'b00, {2{w_phase_nx}}, 2'b00}; end
            ST_EDIT_S: begin w_es_nx = ES_SEC;  w_mask_nx = {4'b0000, {2{w_phase_nx}}}; end
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_run_en  <= 1'b1;
            r_load_en <= 1'b0;
            r_mask    <= '0;
            r_es      <= ES_RUN;
        end else begin
            r_run_en  <= (w_state_nx == ST_RUN);
            r_load_en <= (w_state_nx == ST_COMMIT);
            r_mask    <= w_mask_nx;
            r_es      <= w_es_nx;
        end
    end

    assign run_en     = r_run_en;
    assign load_en    = r_load_en;
    assign load_time  = r_shadow;
    assign blink_mask = r_mask;
    assign edit_state = r_es;

endmodule
